pmp_seq_checker: RTL and testbench

Sequential, parametrised successor to the combinational PMP unit. It checks one request at a time against up to 64 PMP entries, evaluating `ENTRIES_PER_CYCLE` entries per clock and stopping at the first applicable match. Requests and responses use valid/ready handshakes, and a sticky register logs the first denied access. It sits between the AXI IO-PMP request front-end and the grant/deny logic, so large entry counts no longer sit on a single-cycle combinational path.

---
 rtl/pmp_seq_checker_pkg.sv | 59 +++++
 rtl/pmp_seq_checker_if.sv | 48 ++++
 rtl/pmp_seq_checker_entry.sv | 55 +++++
 rtl/pmp_seq_checker.sv | 187 ++++++++++++++++++
 tb/tb_pmp_seq_checker.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmp_seq_checker_pkg.sv
`default_nettype none
//==============================================================================
// Package : pmp_seq_checker_pkg
// Brief   : PMP types and helpers shared by the sequential PMP checker.
// Rev     : 1.0
//==============================================================================
package pmp_seq_checker_pkg;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_M = 2'b11
   } priv_lvl_t;

   typedef enum logic [2:0] {
      ACCESS_NONE  = 3'b000,
      ACCESS_READ  = 3'b001,
      ACCESS_WRITE = 3'b010,
      ACCESS_EXEC  = 3'b100
   } pmp_access_t;

   typedef enum logic [1:0] {
      OFF   = 2'b00,
      TOR   = 2'b01,
      NA4   = 2'b10,
      NAPOT = 2'b11
   } pmp_addr_mode_t;

   typedef struct packed {
      logic x;
      logic w;
      logic r;
   } pmpcfg_access_t;

   typedef struct packed {
      logic           locked;
      logic [1:0]     reserved;
      pmp_addr_mode_t addr_mode;
      pmpcfg_access_t access_type;
   } pmpcfg_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } pmp_seq_state_e;

   localparam int unsigned C_MAX_LANES = 64;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [5:0] lowest_set_idx(input logic [C_MAX_LANES-1:0] vec);
      lowest_set_idx = '0;
      for (int i = C_MAX_LANES - 1; i >= 0; i--) begin
         if (vec[i]) lowest_set_idx = 6'(i);
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/pmp_seq_checker_if.sv
`default_nettype none
//==============================================================================
// Interface : pmp_seq_checker_if
// Brief     : Request/response handshakes and error log of the PMP checker.
// Rev       : 1.0
//==============================================================================
interface pmp_seq_checker_if
   import pmp_seq_checker_pkg::*;
#(
   parameter int unsigned PLEN     = 56,
   parameter int unsigned ID_WIDTH = 4,
   parameter int unsigned IDX_W    = 4
);
   logic                req_valid_i;
   logic                req_ready_o;
   logic [PLEN-1:0]     req_addr_i;
   pmp_access_t         req_access_i;
   priv_lvl_t           req_priv_i;
   logic [ID_WIDTH-1:0] req_id_i;

   logic                rsp_valid_o;
   logic                rsp_ready_i;
   logic                rsp_allow_o;
   logic                rsp_match_o;
   logic [IDX_W-1:0]    rsp_entry_o;
   logic [ID_WIDTH-1:0] rsp_id_o;

   logic                err_valid_o;
   logic [PLEN-1:0]     err_addr_o;
   pmp_access_t         err_access_o;
   priv_lvl_t           err_priv_o;
   logic                err_clear_i;

   modport master (
      output req_valid_i, req_addr_i, req_access_i, req_priv_i, req_id_i,
      output rsp_ready_i, err_clear_i,
      input  req_ready_o, rsp_valid_o, rsp_allow_o, rsp_match_o, rsp_entry_o, rsp_id_o,
      input  err_valid_o, err_addr_o, err_access_o, err_priv_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_access_i, req_priv_i, req_id_i,
      input  rsp_ready_i, err_clear_i,
      output req_ready_o, rsp_valid_o, rsp_allow_o, rsp_match_o, rsp_entry_o, rsp_id_o,
      output err_valid_o, err_addr_o, err_access_o, err_priv_o
   );
endinterface
`default_nettype wire

// File: rtl/pmp_seq_checker_entry.sv
`default_nettype none
//==============================================================================
// Module : pmp_seq_checker_entry
// Brief  : Address match of a single PMP entry (TOR / NA4 / NAPOT).
// Rev    : 1.0
//==============================================================================
module pmp_seq_checker_entry
   import pmp_seq_checker_pkg::*;
#(
   parameter int unsigned PLEN           = 56,
   parameter int unsigned PMP_LEN        = 54,
   parameter int unsigned PMPGranularity = 0
) (
   input  logic [PLEN-1:0]    addr_i,
   input  logic [PMP_LEN-1:0] conf_addr_i,
   input  logic [PMP_LEN-1:0] conf_addr_prev_i,
   input  pmp_addr_mode_t     addr_mode_i,
   output logic               match_o
);
   localparam logic [PLEN-1:0] C_GRAN_MASK = {PLEN{1'b1}} << (PMPGranularity + 2);

   logic [PLEN-1:0] w_base;
   logic [PLEN-1:0] w_prev_base;
   logic [PLEN-1:0] w_mask;
   int unsigned     w_ones;
   int unsigned     w_size;
   logic            w_run;

   assign w_base      = PLEN'({conf_addr_i, 2'b00});
   assign w_prev_base = PLEN'({conf_addr_prev_i, 2'b00});

   // NAPOT region size is encoded by the run of trailing ones in the address.
   always_comb begin
      w_ones = 0;
      w_run  = 1'b1;
      for (int b = 0; b < PMP_LEN; b++) begin
         if (w_run && conf_addr_i[b]) w_ones = w_ones + 1;
         else                         w_run  = 1'b0;
      end
      w_size = (addr_mode_i == NA4) ? 2 : w_ones + 3;
      if (w_size < PMPGranularity + 2) w_size = PMPGranularity + 2;
      w_mask = (w_size >= PLEN) ? '0 : ({PLEN{1'b1}} << w_size);
   end

   always_comb begin
      match_o = 1'b0;
      case (addr_mode_i)
         TOR:        match_o = (addr_i >= (w_prev_base & C_GRAN_MASK)) &&
                               (addr_i <  (w_base & C_GRAN_MASK));
         NA4, NAPOT: match_o = ((addr_i & w_mask) == (w_base & w_mask));
         default:    match_o = 1'b0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/pmp_seq_checker.sv
`default_nettype none
//==============================================================================
// Module : pmp_seq_checker
// Brief  : Multi-cycle PMP check, ENTRIES_PER_CYCLE entries per clock, first match wins.
// Rev    : 1.0
//==============================================================================
module pmp_seq_checker
   import pmp_seq_checker_pkg::*;
#(
   parameter int unsigned PLEN              = 56,
   parameter int unsigned PMP_LEN           = 54,
   parameter int unsigned NR_ENTRIES        = 16,
   parameter int unsigned ENTRIES_PER_CYCLE = 4,
   parameter int unsigned PMPGranularity    = 0,
   parameter int unsigned ID_WIDTH          = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   pmp_seq_checker_if.slave                  bus,
   input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0] conf_addr_i,
   input  pmpcfg_t [NR_ENTRIES-1:0]          conf_i
);
   localparam int unsigned EPC    = ENTRIES_PER_CYCLE;
   localparam int unsigned G      = NR_ENTRIES / EPC;
   localparam int unsigned G_W    = (G > 1) ? $clog2(G) : 1;
   localparam int unsigned IDX_W  = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
   localparam int unsigned LANE_W = (EPC > 1) ? $clog2(EPC) : 1;

   pmp_seq_state_e      r_state;
   logic [G_W-1:0]      r_g;
   logic [PLEN-1:0]     r_addr;
   pmp_access_t         r_access;
   priv_lvl_t           r_priv;
   logic [ID_WIDTH-1:0] r_id;

   logic                r_rsp_valid;
   logic                r_rsp_allow;
   logic                r_rsp_match;
   logic [IDX_W-1:0]    r_rsp_entry;
   logic [ID_WIDTH-1:0] r_rsp_id;

   logic                r_err_valid;
   logic [PLEN-1:0]     r_err_addr;
   pmp_access_t         r_err_access;
   priv_lvl_t           r_err_priv;

   logic [IDX_W-1:0]               w_base;
   logic [EPC-1:0][IDX_W-1:0]      w_idx;
   logic [EPC-1:0][PMP_LEN-1:0]    w_addr;
   logic [EPC-1:0][PMP_LEN-1:0]    w_prev;
   pmp_addr_mode_t [EPC-1:0]       w_mode;
   pmpcfg_access_t [EPC-1:0]       w_perm;
   logic [EPC-1:0]                 w_lock;
   logic [EPC-1:0]                 w_match;
   logic [EPC-1:0]                 w_hit;
   logic [LANE_W-1:0]              w_win_lane;
   logic [IDX_W-1:0]               w_win_idx;
   logic [2:0]                     w_req_bits;
   logic                           w_win_allow;
   logic                           w_last_group;
   logic                           w_rsp_hs;
   logic                           w_log;

   assign w_base = IDX_W'(r_g * EPC);

   for (genvar k = 0; k < EPC; k++) begin : g_lane
      assign w_idx[k]  = w_base + IDX_W'(k);
      assign w_addr[k] = conf_addr_i[w_idx[k]];
      assign w_mode[k] = conf_i[w_idx[k]].addr_mode;
      assign w_perm[k] = conf_i[w_idx[k]].access_type;
      assign w_lock[k] = conf_i[w_idx[k]].locked;

      // Lane 0 takes its TOR lower bound from the last entry of the previous group.
      if (k == 0) begin : g_first
         assign w_prev[k] = (r_g == '0) ? '0 : conf_addr_i[w_base - IDX_W'(1)];
      end else begin : g_rest
         assign w_prev[k] = w_addr[k-1];
      end

      pmp_seq_checker_entry #(
         .PLEN           (PLEN),
         .PMP_LEN        (PMP_LEN),
         .PMPGranularity (PMPGranularity)
      ) u_entry (
         .addr_i           (r_addr),
         .conf_addr_i      (w_addr[k]),
         .conf_addr_prev_i (w_prev[k]),
         .addr_mode_i      (w_mode[k]),
         .match_o          (w_match[k])
      );

      assign w_hit[k] = w_match[k] && ((r_priv != PRIV_LVL_M) || w_lock[k]);
   end

   assign w_win_lane   = LANE_W'(lowest_set_idx(C_MAX_LANES'(w_hit)));
   assign w_win_idx    = w_base + IDX_W'(w_win_lane);
   assign w_req_bits   = r_access;
   assign w_win_allow  = ((w_req_bits & w_perm[w_win_lane]) == w_req_bits);
   assign w_last_group = (r_g == G_W'(G - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_g         <= '0;
         r_addr      <= '0;
         r_access    <= ACCESS_NONE;
         r_priv      <= PRIV_LVL_U;
         r_id        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_allow <= 1'b0;
         r_rsp_match <= 1'b0;
         r_rsp_entry <= '0;
         r_rsp_id    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_valid_i) begin
                  r_addr   <= bus.req_addr_i;
                  r_access <= bus.req_access_i;
                  r_priv   <= bus.req_priv_i;
                  r_id     <= bus.req_id_i;
                  r_g      <= '0;
                  r_state  <= SCAN;
               end
            end
            SCAN: begin
               if (|w_hit) begin
                  r_rsp_allow <= w_win_allow;
                  r_rsp_match <= 1'b1;
                  r_rsp_entry <= w_win_idx;
                  r_rsp_id    <= r_id;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end else if (w_last_group) begin
                  r_rsp_allow <= (r_priv == PRIV_LVL_M);
                  r_rsp_match <= 1'b0;
                  r_rsp_entry <= '0;
                  r_rsp_id    <= r_id;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end else begin
                  r_g <= r_g + 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // A clear coinciding with a denial still records the new denial.
   assign w_rsp_hs = r_rsp_valid && bus.rsp_ready_i;
   assign w_log    = w_rsp_hs && !r_rsp_allow && (!r_err_valid || bus.err_clear_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err_valid  <= 1'b0;
         r_err_addr   <= '0;
         r_err_access <= ACCESS_NONE;
         r_err_priv   <= PRIV_LVL_U;
      end else if (w_log) begin
         r_err_valid  <= 1'b1;
         r_err_addr   <= r_addr;
         r_err_access <= r_access;
         r_err_priv   <= r_priv;
      end else if (bus.err_clear_i) begin
         r_err_valid  <= 1'b0;
      end
   end

   assign bus.req_ready_o  = (r_state == IDLE);
   assign bus.rsp_valid_o  = r_rsp_valid;
   assign bus.rsp_allow_o  = r_rsp_allow;
   assign bus.rsp_match_o  = r_rsp_match;
   assign bus.rsp_entry_o  = r_rsp_entry;
   assign bus.rsp_id_o     = r_rsp_id;
   assign bus.err_valid_o  = r_err_valid;
   assign bus.err_addr_o   = r_err_addr;
   assign bus.err_access_o = r_err_access;
   assign bus.err_priv_o   = r_err_priv;
endmodule
`default_nettype wire

// File: tb/tb_pmp_seq_checker.sv
`default_nettype none
//==============================================================================
// Module : tb_pmp_seq_checker
// Brief  : Directed vector table plus hand-written handshake/error-log/reset sequences.
// Rev    : 1.0
//==============================================================================
module tb_pmp_seq_checker;
   import pmp_seq_checker_pkg::*;

   logic clk;
   logic rst_n;
   logic [15:0][53:0] conf_addr;
   pmpcfg_t [15:0]    conf;
   int n_checks;
   int n_err;

   pmp_seq_checker_if #(.PLEN(56), .ID_WIDTH(4), .IDX_W(4)) bus ();

   pmp_seq_checker #(
      .PLEN(56), .PMP_LEN(54), .NR_ENTRIES(16), .ENTRIES_PER_CYCLE(4),
      .PMPGranularity(0), .ID_WIDTH(4)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bus         (bus),
      .conf_addr_i (conf_addr),
      .conf_i      (conf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          cfg;
      priv_lvl_t   priv;
      pmp_access_t acc;
      logic [55:0] addr;
      logic        allow;
      logic        match;
      int          entry;
      int          cyc;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic pmpcfg_t mk_cfg(input logic l, input pmp_addr_mode_t m, input logic [2:0] xwr);
      pmpcfg_t c;
      c.locked        = l;
      c.reserved      = 2'b00;
      c.addr_mode     = m;
      c.access_type.x = xwr[2];
      c.access_type.w = xwr[1];
      c.access_type.r = xwr[0];
      return c;
   endfunction

   task automatic load_cfg(input int sel);
      for (int i = 0; i < 16; i++) begin
         conf[i]      = mk_cfg(1'b0, OFF, 3'b000);
         conf_addr[i] = '0;
      end
      case (sel)
         0: begin
            conf_addr[4] = 54'h400;
            conf_addr[5] = 54'h800;
            conf[5]      = mk_cfg(1'b0, TOR, 3'b001);
         end
         2: begin
            conf_addr[2] = 54'h21FF;
            conf[2]      = mk_cfg(1'b1, NAPOT, 3'b011);
            conf_addr[3] = 54'h21FF;
            conf[3]      = mk_cfg(1'b0, NAPOT, 3'b111);
         end
         3: begin
            conf_addr[7] = 54'h1000;
            conf_addr[8] = 54'h1100;
            conf[8]      = mk_cfg(1'b0, TOR, 3'b011);
         end
         default: ;
      endcase
   endtask

   task automatic drive_req(input priv_lvl_t p, input pmp_access_t a, input logic [55:0] ad,
                            input logic [3:0] id);
      bus.req_valid_i  = 1'b1;
      bus.req_priv_i   = p;
      bus.req_access_i = a;
      bus.req_addr_i   = ad;
      bus.req_id_i     = id;
   endtask

   // Entered just after the acceptance edge; returns at the negedge of the response cycle.
   task automatic wait_rsp(output int cyc);
      bit got;
      got = 1'b0;
      cyc = 1;
      while (!got && cyc < 30) begin
         @(negedge clk);
         if (bus.rsp_valid_o) got = 1'b1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!got) begin
         n_checks++;
         n_err++;
         $display("FAIL rsp_timeout: got no rsp_valid expected within 30 cycles");
      end
   endtask

   task automatic do_req(input priv_lvl_t p, input pmp_access_t a, input logic [55:0] ad,
                         input logic [3:0] id, output int cyc);
      drive_req(p, a, ad, id);
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      wait_rsp(cyc);
   endtask

   task automatic finish_rsp();
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic pulse_clear();
      bus.err_clear_i = 1'b1;
      @(posedge clk); #1;
      bus.err_clear_i = 1'b0;
   endtask

   initial begin
      int cyc;
      bit seen;
      n_checks = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b0;
      bus.err_clear_i = 1'b0;
      drive_req(PRIV_LVL_U, ACCESS_NONE, '0, '0);
      bus.req_valid_i = 1'b0;
      load_cfg(1);

      vecs[0]  = '{0, PRIV_LVL_U, ACCESS_READ,  56'h1800, 1'b1, 1'b1, 5, 3};
      vecs[1]  = '{0, PRIV_LVL_U, ACCESS_READ,  56'h0FFC, 1'b0, 1'b0, 0, 5};
      vecs[2]  = '{0, PRIV_LVL_U, ACCESS_READ,  56'h1000, 1'b1, 1'b1, 5, 3};
      vecs[3]  = '{0, PRIV_LVL_U, ACCESS_READ,  56'h2000, 1'b0, 1'b0, 0, 5};
      vecs[4]  = '{0, PRIV_LVL_M, ACCESS_READ,  56'h1800, 1'b1, 1'b0, 0, 5};
      vecs[5]  = '{0, PRIV_LVL_S, ACCESS_EXEC,  56'h1FFC, 1'b0, 1'b1, 5, 3};
      vecs[6]  = '{1, PRIV_LVL_M, ACCESS_READ,  56'h0,    1'b1, 1'b0, 0, 5};
      vecs[7]  = '{1, PRIV_LVL_S, ACCESS_READ,  56'h0,    1'b0, 1'b0, 0, 5};
      vecs[8]  = '{2, PRIV_LVL_M, ACCESS_EXEC,  56'h8010, 1'b0, 1'b1, 2, 2};
      vecs[9]  = '{2, PRIV_LVL_U, ACCESS_EXEC,  56'h8FFC, 1'b0, 1'b1, 2, 2};
      vecs[10] = '{2, PRIV_LVL_M, ACCESS_EXEC,  56'h9000, 1'b1, 1'b0, 0, 5};
      vecs[11] = '{2, PRIV_LVL_U, ACCESS_READ,  56'h8000, 1'b1, 1'b1, 2, 2};
      vecs[12] = '{2, PRIV_LVL_M, ACCESS_READ,  56'h7FFC, 1'b1, 1'b0, 0, 5};
      vecs[13] = '{3, PRIV_LVL_U, ACCESS_WRITE, 56'h4200, 1'b1, 1'b1, 8, 4};
      vecs[14] = '{3, PRIV_LVL_U, ACCESS_WRITE, 56'h4400, 1'b0, 1'b0, 0, 5};
      vecs[15] = '{3, PRIV_LVL_U, ACCESS_EXEC,  56'h4000, 1'b0, 1'b1, 8, 4};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset_req_ready", 64'(bus.req_ready_o), 64'd1);
      chk("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk("reset_rsp_allow", 64'(bus.rsp_allow_o), 64'd0);
      chk("reset_rsp_match", 64'(bus.rsp_match_o), 64'd0);
      chk("reset_rsp_entry", 64'(bus.rsp_entry_o), 64'd0);
      chk("reset_rsp_id",    64'(bus.rsp_id_o),    64'd0);
      chk("reset_err_valid", 64'(bus.err_valid_o), 64'd0);
      chk("reset_err_addr",  64'(bus.err_addr_o),  64'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) begin
         load_cfg(vecs[i].cfg);
         do_req(vecs[i].priv, vecs[i].acc, vecs[i].addr, 4'(i), cyc);
         $display("vector %0d addr=0x%0h", i, vecs[i].addr);
         chk("vec_allow", 64'(bus.rsp_allow_o), 64'(vecs[i].allow));
         chk("vec_match", 64'(bus.rsp_match_o), 64'(vecs[i].match));
         chk("vec_entry", 64'(bus.rsp_entry_o), 64'(vecs[i].entry));
         chk("vec_id",    64'(bus.rsp_id_o),    64'(i));
         chk("vec_cycle", 64'(cyc),             64'(vecs[i].cyc));
         finish_rsp();
      end

      // Error log: first denial captured, second dropped.
      pulse_clear();
      chk("err_cleared", 64'(bus.err_valid_o), 64'd0);
      load_cfg(0);
      do_req(PRIV_LVL_U, ACCESS_WRITE, 56'h1800, 4'd3, cyc);
      chk("deny_w_allow", 64'(bus.rsp_allow_o), 64'd0);
      chk("deny_w_entry", 64'(bus.rsp_entry_o), 64'd5);
      finish_rsp();
      chk("log_valid",  64'(bus.err_valid_o),  64'd1);
      chk("log_addr",   64'(bus.err_addr_o),   64'h1800);
      chk("log_access", 64'(bus.err_access_o), 64'(ACCESS_WRITE));
      chk("log_priv",   64'(bus.err_priv_o),   64'(PRIV_LVL_U));
      do_req(PRIV_LVL_S, ACCESS_EXEC, 56'h1FFC, 4'd4, cyc);
      chk("deny2_allow", 64'(bus.rsp_allow_o), 64'd0);
      finish_rsp();
      chk("log_kept_valid",  64'(bus.err_valid_o),  64'd1);
      chk("log_kept_addr",   64'(bus.err_addr_o),   64'h1800);
      chk("log_kept_access", 64'(bus.err_access_o), 64'(ACCESS_WRITE));
      chk("log_kept_priv",   64'(bus.err_priv_o),   64'(PRIV_LVL_U));

      // Back-pressure: response held, pending request waits for the handshake.
      drive_req(PRIV_LVL_U, ACCESS_READ, 56'h1800, 4'd9);
      @(posedge clk); #1;
      drive_req(PRIV_LVL_M, ACCESS_READ, 56'h0, 4'd10);
      wait_rsp(cyc);
      chk("stall_cycle", 64'(cyc), 64'd3);
      for (int s = 0; s < 5; s++) begin
         if (s > 0) @(negedge clk);
         chk("stall_valid",     64'(bus.rsp_valid_o), 64'd1);
         chk("stall_allow",     64'(bus.rsp_allow_o), 64'd1);
         chk("stall_entry",     64'(bus.rsp_entry_o), 64'd5);
         chk("stall_id",        64'(bus.rsp_id_o),    64'd9);
         chk("stall_req_ready", 64'(bus.req_ready_o), 64'd0);
      end
      finish_rsp();
      chk("post_hs_ready", 64'(bus.req_ready_o), 64'd1);
      chk("post_hs_valid", 64'(bus.rsp_valid_o), 64'd0);
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      wait_rsp(cyc);
      chk("pending_id",    64'(bus.rsp_id_o),    64'd10);
      chk("pending_match", 64'(bus.rsp_match_o), 64'd0);
      chk("pending_allow", 64'(bus.rsp_allow_o), 64'd1);
      chk("pending_cycle", 64'(cyc),             64'd5);
      finish_rsp();

      // Clear and a new denial in the same cycle: new denial wins.
      do_req(PRIV_LVL_S, ACCESS_EXEC, 56'h1FFC, 4'd5, cyc);
      chk("pre_clr_valid", 64'(bus.err_valid_o), 64'd1);
      bus.err_clear_i = 1'b1;
      finish_rsp();
      bus.err_clear_i = 1'b0;
      chk("clr_deny_valid",  64'(bus.err_valid_o),  64'd1);
      chk("clr_deny_addr",   64'(bus.err_addr_o),   64'h1FFC);
      chk("clr_deny_access", 64'(bus.err_access_o), 64'(ACCESS_EXEC));
      chk("clr_deny_priv",   64'(bus.err_priv_o),   64'(PRIV_LVL_S));
      pulse_clear();
      chk("clear_only", 64'(bus.err_valid_o), 64'd0);

      // Reset in the middle of a scan.
      do_req(PRIV_LVL_U, ACCESS_WRITE, 56'h1800, 4'd6, cyc);
      finish_rsp();
      chk("pre_rst_log", 64'(bus.err_valid_o), 64'd1);
      load_cfg(1);
      drive_req(PRIV_LVL_M, ACCESS_READ, 56'h0, 4'd7);
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_async_ready", 64'(bus.req_ready_o), 64'd1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.rsp_valid_o) seen = 1'b1;
      end
      chk("rst_no_rsp",     64'(seen),             64'd0);
      chk("rst_req_ready",  64'(bus.req_ready_o),  64'd1);
      chk("rst_rsp_allow",  64'(bus.rsp_allow_o),  64'd0);
      chk("rst_rsp_match",  64'(bus.rsp_match_o),  64'd0);
      chk("rst_rsp_entry",  64'(bus.rsp_entry_o),  64'd0);
      chk("rst_rsp_id",     64'(bus.rsp_id_o),     64'd0);
      chk("rst_err_valid",  64'(bus.err_valid_o),  64'd0);
      chk("rst_err_addr",   64'(bus.err_addr_o),   64'd0);
      chk("rst_err_access", 64'(bus.err_access_o), 64'd0);
      chk("rst_err_priv",   64'(bus.err_priv_o),   64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
